// File: rtl/uart_tx_drain.sv
// UART transmit engine sitting behind the TX FIFO: pops one byte per frame and
// serialises it as start, LSB-first data, optional parity and stop bits.
module uart_tx_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [DATA_WIDTH-1:0] FifoQ,
    input  logic                  FifoEmpty,
    output logic                  FifoRdEn,
    input  logic [DIV_WIDTH-1:0]  Divisor,
    input  logic                  TxEnable,
    output logic                  Tx,
    output logic                  Busy,
    output logic                  TxDone
);
    // One counter serves both the data bits and the stop bits.
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0]  period_q, period_d;
    logic [DIV_WIDTH-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  bit_end;
    logic                  last_stop;
    logic                  can_pop;
    logic [DIV_WIDTH-1:0]  div_eff;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        shift_d   = shift_q;
        period_d  = period_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;

        div_eff   = (Divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : Divisor;
        bit_end   = (timer_q == '0);
        timer_d   = bit_end ? timer_q : timer_q - DIV_WIDTH'(1);
        last_stop = (state_q == S_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
        can_pop   = TxEnable && !FifoEmpty;
        // Gated by reset so no pop can leak out while the block is held in reset.
        FifoRdEn  = Reset_n && can_pop && ((state_q == S_IDLE) || last_stop);

        case (state_q)
            S_IDLE: begin
                if (can_pop) state_d = S_FETCH;
            end
            S_FETCH: begin
                shift_d   = FifoQ;
                period_d  = div_eff;
                timer_d   = div_eff - DIV_WIDTH'(1);
                bit_cnt_d = '0;
                parity_d  = 1'b0;
                state_d   = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = period_q - DIV_WIDTH'(1);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d  = period_q - DIV_WIDTH'(1);
                    shift_d  = shift_q >> 1;
                    parity_d = parity_q ^ shift_q[0];
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    timer_d   = period_q - DIV_WIDTH'(1);
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    timer_d = period_q - DIV_WIDTH'(1);
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = FifoRdEn ? S_FETCH : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next-state values.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = (PARITY == 2) ? parity_d : ~parity_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (timer_d == '0) && (bit_cnt_d == LAST_STOP);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset drives the line to its idle-high level.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            period_q  <= '0;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            period_q  <= period_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign Busy   = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three instances (no parity / odd+2 stop / even+2 stop),
// each fed by a small FIFO model; frames are checked clock by clock.
module tb_uart_tx_drain;
    localparam int NI    = 3;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   divisor;
    logic          tx_enable;
    logic [NI-1:0] tx, busy, done, rd_en, fifo_empty;
    logic [7:0]    fq [NI];

    logic [7:0]    mem [NI][DEPTH];
    int            wr_ptr [NI] = '{default: 0};
    int            rd_ptr [NI] = '{default: 0};
    int            pop_cnt [NI] = '{default: 0};
    logic [NI-1:0] bad_pop = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          g;
        logic [7:0]  din;
        logic [15:0] div;
        int          p;
        int          nbits;
        logic [15:0] bits;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign fifo_empty[g] = (wr_ptr[g] == rd_ptr[g]);
        uart_tx_drain #(
            .DATA_WIDTH(8),
            .STOP_BITS (g == 0 ? 1 : 2),
            .PARITY    (g),
            .DIV_WIDTH (16)
        ) u_dut (
            .Clock    (clk),
            .Reset_n  (rst_n),
            .FifoQ    (fq[g]),
            .FifoEmpty(fifo_empty[g]),
            .FifoRdEn (rd_en[g]),
            .Divisor  (divisor),
            .TxEnable (tx_enable),
            .Tx       (tx[g]),
            .Busy     (busy[g]),
            .TxDone   (done[g])
        );
    end

    // FIFO read side: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rd_en[g] === 1'b1) begin
                if (fifo_empty[g]) begin
                    bad_pop[g] <= 1'b1;
                end else begin
                    fq[g]     <= mem[g][rd_ptr[g] % DEPTH];
                    rd_ptr[g] <= rd_ptr[g] + 1;
                end
                pop_cnt[g] <= pop_cnt[g] + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [7:0] d);
        mem[g][wr_ptr[g] % DEPTH] = d;
        wr_ptr[g] = wr_ptr[g] + 1;
    endtask

    // Frame as a list of line levels, index 0 = start bit.
    function automatic int model_len(input int g);
        return 1 + 8 + ((g != 0) ? 1 : 0) + ((g == 0) ? 1 : 2);
    endfunction

    function automatic logic [15:0] model_bits(input int g, input logic [7:0] d);
        logic [15:0] b;
        int ones;
        b    = '1;
        b[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            b[1 + i] = d[i];
            if (d[i]) ones++;
        end
        if (g == 1) b[9] = ((ones % 2) == 0);
        else if (g == 2) b[9] = ((ones % 2) == 1);
        return b;
    endfunction

    task automatic wait_pop(input int g);
        int n;
        n = 0;
        #1;
        while (rd_en[g] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("g%0d_pop_seen", g), rd_en[g], 1);
    endtask

    // Starts on the pop clock; ends on the final stop clock of the frame.
    task automatic frame_after_pop(input int g, input logic [15:0] bits, input int nbits,
                                   input int p, input logic last_pop);
        logic last;
        tick();
        check($sformatf("g%0d_fetch_tx", g), tx[g], 1);
        check($sformatf("g%0d_fetch_busy", g), busy[g], 1);
        check($sformatf("g%0d_fetch_rden", g), rd_en[g], 0);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < p; c++) begin
                tick();
                last = (k == nbits - 1) && (c == p - 1);
                check($sformatf("g%0d_bit%0d_clk%0d_tx", g, k, c), tx[g], bits[k]);
                check($sformatf("g%0d_bit%0d_clk%0d_done", g, k, c), done[g], last);
                check($sformatf("g%0d_bit%0d_clk%0d_busy", g, k, c), busy[g], 1);
                check($sformatf("g%0d_bit%0d_clk%0d_rden", g, k, c), rd_en[g], last ? last_pop : 1'b0);
            end
        end
    endtask

    task automatic check_idle(input int g, input string tag);
        check({tag, "_tx"}, tx[g], 1);
        check({tag, "_busy"}, busy[g], 0);
        check({tag, "_done"}, done[g], 0);
    endtask

    initial begin
        int          g;
        int          nb;
        int          p;
        logic [15:0] dv;
        logic [7:0]  bytes [2];

        vecs[0] = '{0, 8'hA5, 16'd4, 4, 10, 16'h034A};
        vecs[1] = '{0, 8'h00, 16'd0, 2, 10, 16'h0200};
        vecs[2] = '{0, 8'hFF, 16'd1, 2, 10, 16'h03FE};
        vecs[3] = '{0, 8'h3C, 16'd3, 3, 10, 16'h0278};
        vecs[4] = '{0, 8'h81, 16'd5, 5, 10, 16'h0302};
        vecs[5] = '{1, 8'h07, 16'd4, 4, 12, 16'h0C0E};
        vecs[6] = '{2, 8'h07, 16'd4, 4, 12, 16'h0E0E};

        rst_n     = 1'b0;
        divisor   = 16'd4;
        tx_enable = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            check_idle(i, $sformatf("g%0d_reset", i));
            check($sformatf("g%0d_reset_rden", i), rd_en[i], 0);
        end
        rst_n = 1'b1;
        tick();
        tx_enable = 1'b1;

        for (int i = 0; i < 7; i++) begin
            divisor = vecs[i].div;
            push(vecs[i].g, vecs[i].din);
            wait_pop(vecs[i].g);
            frame_after_pop(vecs[i].g, vecs[i].bits, vecs[i].nbits, vecs[i].p, 1'b0);
            tick();
            check_idle(vecs[i].g, $sformatf("vec%0d_end", i));
            tick();
        end

        // Back-to-back: second pop on the last stop clock, one FETCH clock gap.
        divisor = 16'd4;
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_pop(0);
        frame_after_pop(0, model_bits(0, 8'h00), 10, 4, 1'b1);
        frame_after_pop(0, model_bits(0, 8'hFF), 10, 4, 1'b0);
        tick();
        check_idle(0, "b2b_end");

        // Divisor change mid-frame applies to the following frame only.
        push(0, 8'h11);
        push(0, 8'h22);
        wait_pop(0);
        fork
            frame_after_pop(0, model_bits(0, 8'h11), 10, 4, 1'b1);
            begin
                repeat (8) tick();
                divisor = 16'd8;
            end
        join
        frame_after_pop(0, model_bits(0, 8'h22), 10, 8, 1'b0);
        tick();
        check_idle(0, "div_change_end");
        divisor = 16'd4;

        // Disabled with data waiting: nothing happens.
        tx_enable = 1'b0;
        push(0, 8'h5A);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("disabled_rden", rd_en[0], 0);
            check("disabled_tx", tx[0], 1);
        end
        tx_enable = 1'b1;
        wait_pop(0);
        frame_after_pop(0, model_bits(0, 8'h5A), 10, 4, 1'b0);
        tick();
        check_idle(0, "reenable_end");

        // Enable dropped mid-frame: frame completes, the next byte stays queued.
        push(0, 8'hC3);
        push(0, 8'h3C);
        wait_pop(0);
        fork
            frame_after_pop(0, model_bits(0, 8'hC3), 10, 4, 1'b0);
            begin
                repeat (6) tick();
                tx_enable = 1'b0;
            end
        join
        tick();
        check_idle(0, "drop_end");
        repeat (10) begin
            tick();
            check("drop_no_pop", rd_en[0], 0);
        end
        check("drop_pop_count", pop_cnt[0], wr_ptr[0] - 1);
        tx_enable = 1'b1;
        wait_pop(0);
        frame_after_pop(0, model_bits(0, 8'h3C), 10, 4, 1'b0);
        tick();
        check_idle(0, "drop_resume_end");

        // Asynchronous reset in the middle of a data bit.
        push(0, 8'h96);
        wait_pop(0);
        push(0, 8'h69);
        repeat (7) tick();
        check("pre_reset_tx", tx[0], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(0, "async_reset");
        check("async_reset_rden", rd_en[0], 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("release_pop", rd_en[0], 1);
        frame_after_pop(0, model_bits(0, 8'h69), 10, 4, 1'b0);
        tick();
        check_idle(0, "release_end");

        // Randomised frames against the reference model.
        for (int it = 0; it < 24; it++) begin
            g  = int'($urandom_range(0, NI - 1));
            nb = int'($urandom_range(1, 2));
            dv = 16'($urandom_range(0, 6));
            p  = (dv < 16'd2) ? 2 : int'(dv);
            divisor = dv;
            for (int j = 0; j < nb; j++) begin
                bytes[j] = 8'($urandom);
                push(g, bytes[j]);
            end
            wait_pop(g);
            for (int j = 0; j < nb; j++) begin
                frame_after_pop(g, model_bits(g, bytes[j]), model_len(g), p, (j < nb - 1));
            end
            tick();
            check_idle(g, $sformatf("rand%0d_end", it));
            tick();
        end

        for (int i = 0; i < NI; i++) begin
            check($sformatf("g%0d_total_pops", i), pop_cnt[i], wr_ptr[i]);
            check($sformatf("g%0d_pop_when_empty", i), bad_pop[i], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
